// File: rtl/wb_host_pkg.sv
// Shared types for the Wishbone classic host master: FSM states and the
// command/response records held between the request and response sides.
package wb_host_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
    } wbm_cmd_t;

    typedef struct packed {
        logic [WB_DW-1:0] dat;
        logic             err;
    } wbm_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating count of strobe cycles without ack. o_hit is registered-only and
// is high during the cycle whose closing edge completes TIMEOUT strobe cycles.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_hit = (r_cnt == C_LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone B4 classic single-word master: one command in, one bus cycle, one
// response out (read data or timeout error). All outputs come from flops.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    // Internal records are sized by the package; AW/DW must not exceed them.
    wbm_state_t r_state;
    wbm_state_t w_state_nxt;
    wbm_cmd_t   r_cmd;
    wbm_cmd_t   w_cmd_in;
    wbm_rsp_t   r_rsp;
    wbm_rsp_t   w_rsp_nxt;
    logic       w_rsp_load;
    logic       r_cyc;
    logic       r_rsp_vld;
    logic       r_cmd_rdy;
    logic       w_cyc_nxt;
    logic       w_rsp_vld_nxt;
    logic       w_cmd_rdy_nxt;
    logic       w_accept;
    logic       w_hit;
    logic       w_ctr_en;

    assign w_accept = cmd_valid & r_cmd_rdy;
    assign w_ctr_en = (r_state == BUS) & ~wbm_ack_i;

    assign w_cmd_in.we  = cmd_we;
    assign w_cmd_in.adr = WB_AW'(cmd_adr);
    assign w_cmd_in.dat = WB_DW'(cmd_dat);
    assign w_cmd_in.sel = WB_SW'(cmd_sel);

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_clr   (w_accept),
        .i_en    (w_ctr_en),
        .o_hit   (w_hit)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ack is checked before the timeout so a last-cycle ack still completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || w_hit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cyc_nxt     = (w_state_nxt == BUS);
        w_rsp_vld_nxt = (w_state_nxt == RESP);
        w_cmd_rdy_nxt = (w_state_nxt == IDLE);
        w_rsp_load    = 1'b0;
        w_rsp_nxt     = '0;
        if (r_state == BUS) begin
            if (wbm_ack_i) begin
                w_rsp_load    = 1'b1;
                w_rsp_nxt.dat = r_cmd.we ? '0 : WB_DW'(wbm_dat_i);
                w_rsp_nxt.err = 1'b0;
            end else if (w_hit) begin
                w_rsp_load    = 1'b1;
                w_rsp_nxt.dat = '0;
                w_rsp_nxt.err = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_cmd     <= '0;
            r_rsp     <= '0;
            r_cyc     <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_cmd_rdy <= 1'b0;
        end else begin
            r_cyc     <= w_cyc_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
            r_cmd_rdy <= w_cmd_rdy_nxt;
            if (w_accept) begin
                r_cmd <= w_cmd_in;
            end
            if (w_rsp_load) begin
                r_rsp <= w_rsp_nxt;
            end
        end
    end

    assign cmd_ready = r_cmd_rdy;
    assign rsp_valid = r_rsp_vld;
    assign rsp_dat   = DW'(r_rsp.dat);
    assign rsp_err   = r_rsp.err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_cmd.we;
    assign wbm_adr_o = AW'(r_cmd.adr);
    assign wbm_dat_o = DW'(r_cmd.dat);
    assign wbm_sel_o = (DW/8)'(r_cmd.sel);

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with TIMEOUT=8: vector table of single
// transactions plus hand-written backpressure, reset and throughput sequences.
module tb_wb_host_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    always #5 clk = ~clk;

    wb_host_master #(
        .TIMEOUT (TO),
        .AW      (32),
        .DW      (32)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rd;
        bit          noack;
        logic [31:0] exp_dat;
        bit          exp_err;
        int          exp_stb;
    } vec_t;

    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int stb_cnt;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk({v.name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        tick();
        cmd_valid = 1'b0;
        cmd_adr   = 32'hFFFF_FFFF;
        cmd_dat   = ~v.dat;
        cmd_sel   = 4'h0;
        cmd_we    = ~v.we;
        chk({v.name, "_cycstb"}, 64'({wbm_cyc_o, wbm_stb_o}), 64'd3);
        chk({v.name, "_we_sel_adr"}, 64'({wbm_we_o, wbm_sel_o, wbm_adr_o}), 64'({v.we, v.sel, v.adr}));
        chk({v.name, "_wdat"}, 64'(wbm_dat_o), 64'(v.dat));
        stb_cnt = 0;
        while (wbm_stb_o && stb_cnt < TO + 4) begin
            stb_cnt++;
            if (!v.noack && stb_cnt == v.waits + 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.rd;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = 32'hBAD0_0000 | 32'(stb_cnt);
            end
            tick();
            wbm_ack_i = 1'b0;
        end
        chk({v.name, "_stb_cycles"}, 64'(stb_cnt), 64'(v.exp_stb));
        chk({v.name, "_rsp_valid"}, 64'({rsp_valid, wbm_cyc_o}), 64'b10);
        chk({v.name, "_rsp_dat"}, 64'(rsp_dat), 64'(v.exp_dat));
        chk({v.name, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({v.name, "_after_hs"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int vld;
        //           name     we   adr           dat           sel   w  rd            na  exp_dat       err stb
        vecs[0] = '{"wr0",   1'b1, 32'h3000_0004, 32'h0000_0030, 4'hF, 0, 32'hDEAD_BEEF, 0, 32'h0,        0, 1};
        vecs[1] = '{"rd3",   1'b0, 32'h3000_0008, 32'h1111_1111, 4'hF, 3, 32'h0000_0006, 0, 32'h6,        0, 4};
        vecs[2] = '{"tmo",   1'b0, 32'h3000_000C, 32'h0,         4'hF, 0, 32'h0,         1, 32'h0,        1, TO};
        vecs[3] = '{"ackto", 1'b0, 32'h3000_0010, 32'h0,         4'hF, 7, 32'h0000_00A5, 0, 32'hA5,       0, TO};
        vecs[4] = '{"wr2",   1'b1, 32'h3000_0014, 32'hCAFE_F00D, 4'h3, 2, 32'h1234_5678, 0, 32'h0,        0, 3};
        vecs[5] = '{"rd0",   1'b0, 32'h3000_0018, 32'h0,         4'h5, 0, 32'h8765_4321, 0, 32'h8765_4321, 0, 1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        tick();
        tick();
        chk("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
        chk("reset_bus", 64'({wbm_sel_o, wbm_adr_o}), 64'd0);
        chk("reset_dat", 64'({rsp_dat, wbm_dat_o}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        // stray ack while idle must not move the FSM
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5A5A_5A5A;
        tick();
        wbm_ack_i = 1'b0;
        chk("idle_ack_ignored", 64'({cmd_ready, rsp_valid, wbm_cyc_o}), 64'b100);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // response backpressure with a new command already waiting
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h20; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h10; cmd_dat = 32'h44; cmd_sel = 4'h1;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h77;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 64'({cmd_ready, rsp_valid, rsp_err, rsp_dat}), 64'({1'b0, 1'b1, 1'b0, 32'h77}));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_ready_after_hs", 64'({cmd_ready, rsp_valid, wbm_cyc_o}), 64'b100);
        tick();
        cmd_valid = 1'b0;
        chk("bp_accepted", 64'({wbm_cyc_o, wbm_we_o, wbm_adr_o}), 64'({2'b11, 32'h10}));
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("bp_wr_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), 64'({2'b10, 32'h0}));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset in the middle of wait states, then a late ack
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h40; cmd_sel = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_stb", 64'(wbm_stb_o), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_drop", 64'({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}), 64'd0);
        chk("rst_mid_adr", 64'(wbm_adr_o), 64'd0);
        rst_n = 1'b1;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h99;
        tick();
        chk("rst_release", 64'({cmd_ready, rsp_valid, wbm_cyc_o}), 64'b100);
        wbm_ack_i = 1'b0;
        tick();
        chk("rst_late_ack", 64'({cmd_ready, rsp_valid, rsp_dat}), 64'({2'b10, 32'h0}));

        // throughput: zero-wait slave, rsp_ready tied high -> one accept per 3 cycles
        rsp_ready = 1'b1; wbm_ack_i = 1'b1; wbm_dat_i = 32'h55;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h80;
        acc = 0;
        vld = 0;
        for (int i = 0; i < 9; i++) begin
            if (cmd_valid && cmd_ready) acc++;
            if (rsp_valid) vld++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", 64'(acc), 64'd3);
        chk("b2b_responses", 64'(vld), 64'd3);
        tick();
        chk("b2b_idle", 64'({cmd_ready, rsp_valid, wbm_cyc_o, rsp_dat}), 64'({3'b100, 32'h55}));
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
